memory_ext_mp: RTL
==================

MEMORY_EXT_MP -- requirements
Module: memory_ext_mp

Interface
REQ-001 Parameter DMA_SIZE, default 3; address width per channel; depth is 2**DMA_SIZE words.
REQ-002 Parameter DMD_SIZE, default 4; data word width.
REQ-003 Parameter NUM_CH, default 2; number of independent access channels, legal range 1..4.
REQ-004 Parameter RD_LAT, default 2; read latency in clk cycles from request to data, legal range 1..4.
REQ-005 Parameter INIT_FILE, default ""; hex image loaded into the array at time zero, with no load when empty (simulation only).
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 ps_dm_cslt  input  NUM_CH  per-channel chip select.
REQ-009 ps_dm_wrb  input  NUM_CH  per-channel write (1) / read (0).
REQ-010 dg_dm_add  input  NUM_CH*DMA_SIZE  packed addresses, channel c at bits [c*DMA_SIZE +: DMA_SIZE].
REQ-011 bc_dt  input  NUM_CH*DMD_SIZE  packed write data, same packing.
REQ-012 dm_bc_dt  output  NUM_CH*DMD_SIZE  packed registered read data.
REQ-013 dm_rd_vld  output  NUM_CH  per-channel one-cycle pulse marking new read data.
REQ-014 dm_wr_coll  output  1  one-cycle pulse flagging a same-address multi-channel write.

Function
REQ-015 A request SHALL be issued on channel c in any cycle where rst_n=1 and ps_dm_cslt[c]=1, with no back-pressure; every channel accepts one request per cycle.
REQ-016 A write request SHALL update array[add] at the issuing edge (write latency 1).
REQ-017 A read request issued at edge N SHALL sample the array at edge N, and dm_bc_dt slice c plus dm_rd_vld[c]=1 SHALL appear after edge N+RD_LAT-1, i.e. valid during cycle N+RD_LAT.
REQ-018 Read sampling SHALL be write-first: a read at edge N returns data including all writes issued at edges up to and including N, on any channel.
REQ-019 Same-edge writes by several channels to one address SHALL resolve to the lowest channel index; dm_wr_coll SHALL pulse high the following cycle.
REQ-020 When writes to different addresses occur on the same edge, all SHALL commit and dm_wr_coll SHALL stay 0.
REQ-021 Read pipelines SHALL be fully pipelined: back-to-back reads on a channel produce back-to-back dm_rd_vld pulses in issue order.
REQ-022 dm_bc_dt slice c SHALL hold its last read value while dm_rd_vld[c]=0; writes never change dm_bc_dt.
REQ-023 Address arithmetic SHALL be modulo 2**DMA_SIZE with no out-of-range case; address 2**DMA_SIZE-1 is a normal location.
REQ-024 A simultaneous read on channel a and write on channel b to the same address SHALL return the new data (per REQ-018).

Reset
REQ-025 While rst_n=0, dm_bc_dt, dm_rd_vld, dm_wr_coll and all pipeline stages SHALL be 0, and requests SHALL be ignored.
REQ-026 Reset asserted mid-operation SHALL flush in-flight reads, so no dm_rd_vld pulse results from a pre-reset request.
REQ-027 Array contents SHALL NOT be reset and SHALL be preserved across reset.
REQ-028 After rst_n rises, the first request SHALL be accepted at the first rising edge with rst_n=1.

Structure
REQ-029 Shared package memory_ext_pkg SHALL hold default parameter constants, the RD_LAT/NUM_CH legal-range limits and the channel slice-offset helper functions.
REQ-030 A per-channel sub-module memory_ext_rdpipe SHALL implement the RD_LAT-deep valid/data shift register with asynchronous reset, instantiated NUM_CH times via generate.
REQ-031 The array and write-priority logic SHALL reside in memory_ext_mp itself, and parameter-range violations SHALL be reported by an elaboration-time check.

Verification
REQ-032 Reset then ch0 write add=3 data=A, then ch0 read add=3 -> dm_bc_dt[3:0]=A with dm_rd_vld[0]=1 exactly 2 cycles after the read edge (RD_LAT=2).
REQ-033 Same edge ch0 writes add=5 data=1 and ch1 writes add=5 data=2, then read add=5 -> data 1 and dm_wr_coll=1 for one cycle.
REQ-034 Same edge ch0 writes add=7 data=C and ch1 reads add=7 -> ch1 returns C (write-first).
REQ-035 Ch1 reads add 0..7 on consecutive cycles after image load -> 8 consecutive dm_rd_vld[1] pulses with the image values in order, including the wrap at add=7.
REQ-036 Read issued, then rst_n pulled low one cycle later -> no dm_rd_vld pulse and outputs 0; after release, a read of the earlier-written location returns the pre-reset contents.
REQ-037 Repeat REQ-032 with RD_LAT=1 and RD_LAT=4 and NUM_CH=4, DMD_SIZE=16 -> latency equals RD_LAT on all four channels.

Source files
------------

// File: rtl/memory_ext_pkg.sv
// -----------------------------------------------------------------------------
// memory_ext_pkg
// Purpose : Shared constants and helpers for the multi-port memory block.
//           Holds the default parameter values, the legal ranges for
//           NUM_CH / RD_LAT, and the functions that locate a channel's slice
//           inside the packed address and data buses.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package memory_ext_pkg;

  localparam int DEF_DMA_SIZE = 3;
  localparam int DEF_DMD_SIZE = 4;
  localparam int DEF_NUM_CH   = 2;
  localparam int DEF_RD_LAT   = 2;

  localparam int NUM_CH_MIN = 1;
  localparam int NUM_CH_MAX = 4;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // Lowest bit of channel ch's address field in the packed address bus.
  function automatic int add_lo(input int ch, input int dma_size);
    return ch * dma_size;
  endfunction

  // Lowest bit of channel ch's data field in the packed data buses.
  function automatic int dat_lo(input int ch, input int dmd_size);
    return ch * dmd_size;
  endfunction

endpackage

// File: rtl/memory_ext_rdpipe.sv
// -----------------------------------------------------------------------------
// memory_ext_rdpipe
// Purpose : Per-channel read-return pipeline, RD_LAT stages deep. Stage 0
//           captures the (write-first) array data at the issuing edge; the
//           last stage drives the channel's read data and valid pulse.
// Ports   : clk       - clock, all state on rising edge
//           rst_n     - asynchronous active-low reset (flushes all stages)
//           rd_req_i  - read issued this edge
//           rd_dat_i  - array data sampled for this read
//           rd_vld_o  - one-cycle pulse marking new read data
//           rd_dat_o  - read data, holds last value while rd_vld_o is low
// -----------------------------------------------------------------------------
module memory_ext_rdpipe #(
  parameter int RD_LAT = 2,
  parameter int DW     = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_req_i,
  input  logic [DW-1:0] rd_dat_i,
  output logic          rd_vld_o,
  output logic [DW-1:0] rd_dat_o
);

  logic [RD_LAT-1:0] vld_q;
  logic [DW-1:0]     dat_q [RD_LAT];

  // Valid/data shift register; data stages only load when a valid token
  // moves into them, so the final stage holds the last returned value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      vld_q[0] <= rd_req_i;
      if (rd_req_i) begin
        dat_q[0] <= rd_dat_i;
      end
      for (int k = 1; k < RD_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          dat_q[k] <= dat_q[k-1];
        end
      end
    end
  end

  assign rd_vld_o = vld_q[RD_LAT-1];
  assign rd_dat_o = dat_q[RD_LAT-1];

endmodule

// File: rtl/memory_ext_mp.sv
// -----------------------------------------------------------------------------
// memory_ext_mp
// Purpose : NUM_CH-port memory of 2**DMA_SIZE words x DMD_SIZE bits. Every
//           channel can issue one read or write per cycle. Writes commit at
//           the issuing edge; reads sample write-first at the issuing edge and
//           return after RD_LAT cycles. Same-edge writes to one address are
//           resolved to the lowest channel and flagged on dm_wr_coll.
// Ports   : clk        - clock
//           rst_n      - asynchronous active-low reset (array not reset)
//           ps_dm_cslt - per-channel chip select
//           ps_dm_wrb  - per-channel write(1)/read(0)
//           dg_dm_add  - packed addresses, channel c at [c*DMA_SIZE +: DMA_SIZE]
//           bc_dt      - packed write data, channel c at [c*DMD_SIZE +: DMD_SIZE]
//           dm_bc_dt   - packed registered read data
//           dm_rd_vld  - per-channel read-data valid pulse
//           dm_wr_coll - pulse: same-address multi-channel write last edge
// -----------------------------------------------------------------------------
module memory_ext_mp
  import memory_ext_pkg::*;
#(
  parameter int    DMA_SIZE  = DEF_DMA_SIZE,
  parameter int    DMD_SIZE  = DEF_DMD_SIZE,
  parameter int    NUM_CH    = DEF_NUM_CH,
  parameter int    RD_LAT    = DEF_RD_LAT,
  parameter string INIT_FILE = ""
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          ps_dm_cslt,
  input  logic [NUM_CH-1:0]          ps_dm_wrb,
  input  logic [NUM_CH*DMA_SIZE-1:0] dg_dm_add,
  input  logic [NUM_CH*DMD_SIZE-1:0] bc_dt,
  output logic [NUM_CH*DMD_SIZE-1:0] dm_bc_dt,
  output logic [NUM_CH-1:0]          dm_rd_vld,
  output logic                       dm_wr_coll
);

  localparam int DEPTH = 2**DMA_SIZE;

  if ((NUM_CH < NUM_CH_MIN) || (NUM_CH > NUM_CH_MAX) ||
      (RD_LAT < RD_LAT_MIN) || (RD_LAT > RD_LAT_MAX)) begin : g_param_chk
    $error("memory_ext_mp: NUM_CH must be 1..4 and RD_LAT must be 1..4");
  end

  logic [DMD_SIZE-1:0] mem_q  [DEPTH];
  logic [DMA_SIZE-1:0] add_s  [NUM_CH];
  logic [DMD_SIZE-1:0] wdat_s [NUM_CH];
  logic [DMD_SIZE-1:0] rdat_s [NUM_CH];
  logic [NUM_CH-1:0]   wr_en_s;
  logic [NUM_CH-1:0]   rd_req_s;
  logic                coll_d;
  logic                coll_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign add_s[c]    = dg_dm_add[add_lo(c, DMA_SIZE) +: DMA_SIZE];
    assign wdat_s[c]   = bc_dt[dat_lo(c, DMD_SIZE) +: DMD_SIZE];
    // Writes are suppressed in reset; reads are flushed by the pipe reset.
    assign wr_en_s[c]  = rst_n & ps_dm_cslt[c] & ps_dm_wrb[c];
    assign rd_req_s[c] = ps_dm_cslt[c] & ~ps_dm_wrb[c];

    memory_ext_rdpipe #(
      .RD_LAT (RD_LAT),
      .DW     (DMD_SIZE)
    ) u_rdpipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_req_i (rd_req_s[c]),
      .rd_dat_i (rdat_s[c]),
      .rd_vld_o (dm_rd_vld[c]),
      .rd_dat_o (dm_bc_dt[dat_lo(c, DMD_SIZE) +: DMD_SIZE])
    );
  end

  // Array write port: iterate high to low so the lowest channel's
  // non-blocking write lands last and wins a same-address conflict.
  always_ff @(posedge clk) begin
    for (int j = NUM_CH - 1; j >= 0; j--) begin
      if (wr_en_s[j]) begin
        mem_q[add_s[j]] <= wdat_s[j];
      end
    end
  end

  // Write-first read data: bypass same-edge writes, lowest channel wins.
  always_comb begin
    logic [DMD_SIZE-1:0] sel_v;
    for (int c = 0; c < NUM_CH; c++) begin
      sel_v = mem_q[add_s[c]];
      for (int j = NUM_CH - 1; j >= 0; j--) begin
        if (wr_en_s[j] && (add_s[j] == add_s[c])) begin
          sel_v = wdat_s[j];
        end else begin
          sel_v = sel_v;
        end
      end
      rdat_s[c] = sel_v;
    end
  end

  // Detect two or more channels writing the same address on this edge.
  always_comb begin
    coll_d = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int j = i + 1; j < NUM_CH; j++) begin
        if (wr_en_s[i] && wr_en_s[j] && (add_s[i] == add_s[j])) begin
          coll_d = 1'b1;
        end else begin
          coll_d = coll_d;
        end
      end
    end
  end

  // Register the collision flag into a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_q <= 1'b0;
    end else begin
      coll_q <= coll_d;
    end
  end

  assign dm_wr_coll = coll_q;

endmodule
